imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer-side companion to the byte-wide, little-endian instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream and writes each one into instruction memory as four byte writes, least-significant byte at the lowest address.
- Holds the pipeline via cpu_hold while a program image is loaded.
- Sits between the boot/testbench source and the instruction memory write port.

Parameters:
- noal, 8, number of instruction-memory address lines (memory has 2**noal bytes).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle load request; sampled only in IDLE.
- base_addr  input  noal  first byte address of the load; latched on accepted start.
- word_count  input  noal-1  number of 32-bit words to load; latched on accepted start.
- in_data  input  32  instruction word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can take a word this cycle.
- mem_we  output  1  byte write enable to instruction memory.
- mem_addr  output  noal  byte address for the write.
- mem_wdata  output  8  byte to write.
- busy  output  1  load in progress.
- cpu_hold  output  1  stall/reset request to the pipeline; identical to busy.
- done  output  1  one-cycle pulse at load completion.
- wrap_err  output  1  sticky flag: the load address wrapped past 2**noal-1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; address counter, remaining count, byte index and word register cleared.
  - in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done and wrap_err all 0.
  - Reset mid-load abandons the load immediately. Bytes already written stay written.
- States IDLE, ACCEPT, WRITE, DONE. busy = cpu_hold = (state != IDLE).
- IDLE:
  - in_ready=0, mem_we=0.
  - start=1 latches base_addr into the address counter and word_count into remaining, and clears wrap_err.
  - Next state is ACCEPT, or DONE if word_count==0.
- start outside IDLE is ignored, with no effect on any state.
- ACCEPT:
  - in_ready=1 combinationally.
  - in_valid=1 latches in_data, clears the byte index, and goes to WRITE.
  - in_valid=0 waits indefinitely with no timeout.
- WRITE (exactly 4 cycles per word):
  - mem_we=1, mem_addr=address counter, mem_wdata=word[8*idx+7:8*idx] for idx 0,1,2,3.
  - The address counter increments by 1 each cycle, modulo 2**noal.
  - Incrementing from 2**noal-1 sets wrap_err. The write still occurs at the wrapped address.
  - After idx=3, remaining decrements. Next state is DONE if remaining was 1, else ACCEPT.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency and throughput:
  - Accepted start at edge N gives ACCEPT in cycle N+1.
  - With in_valid held high, the first byte is written in cycle N+2.
  - Steady state is 5 cycles per word.
  - done is high in cycle N+1+5*word_count.
- mem_addr and mem_wdata are 0 whenever mem_we=0.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[31:0], cleared on accepted start.
  - XOR-accumulates each accepted in_data on its handshake cycle.
  - Value is stable from the done pulse until the next accepted start; reset value 0.
- When undefined: no checksum port or logic; all other behaviour identical.

Test Plan:
- Single word: base_addr=0, word_count=1, in_data=32'h0000_0063, in_valid held.
  - Required: writes 0x63,0x00,0x00,0x00 to addresses 0,1,2,3 in cycles N+2..N+5.
  - Required: done pulses at N+6, then busy=0.
- Multi-word with stalls: base_addr=0, word_count=2, words 32'h0000_8133 then 32'h0000_81b3; in_valid low for 3 cycles before the second word.
  - Required: bytes 33,81,00,00,B3,81,00,00 at addresses 0..7.
  - Required: in_ready high throughout the stall; done once.
- Wrap: noal=8, base_addr=254, word_count=1, word 32'hAABB_CCDD.
  - Required: DD→254, CC→255, BB→0, AA→1; wrap_err=1 after the load, and cleared by the next start.
- Zero count and ignored start: word_count=0 gives done at N+1 with no mem_we. A start pulse during WRITE changes nothing.
- Reset mid-load: assert rst_n=0 during the second WRITE byte.
  - Required: all outputs 0 immediately; IDLE after release; next load behaves normally.
- With IMEM_LOADER_CHECKSUM_EN: words 32'h1234_5678 and 32'hFFFF_0000 give checksum=32'hEDCB_5678 at done.

Source files
------------

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide little-endian instruction memory.
// Optional XOR checksum of accepted words: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int noal = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [noal-1:0] base_addr,
    input  logic [noal-2:0] word_count,
    input  logic [31:0]     in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            mem_we,
    output logic [noal-1:0] mem_addr,
    output logic [7:0]      mem_wdata,
    output logic            busy,
    output logic            cpu_hold,
    output logic            done,
    output logic            wrap_err
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]     checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [noal-1:0] addr_q;
    logic [noal-2:0] remaining_q;
    logic [1:0]      byte_idx_q;
    logic [31:0]     word_q;
    logic            wrap_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (word_count == '0) ? DONE : ACCEPT;
            end
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) state_d = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
                if (byte_idx_q == 2'd3)
                    state_d = (remaining_q == (noal-1)'(1)) ? DONE : ACCEPT;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy      = (state_q != IDLE);
        cpu_hold  = busy;
        mem_addr  = mem_we ? addr_q : '0;
        mem_wdata = mem_we ? word_q[{byte_idx_q, 3'b000} +: 8] : 8'h00;
    end

    assign wrap_err = wrap_q;

    // A start seen outside IDLE falls through every arm below untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            wrap_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q      <= base_addr;
                        remaining_q <= word_count;
                        wrap_q      <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        word_q     <= in_data;
                        byte_idx_q <= '0;
                    end
                end
                WRITE: begin
                    addr_q     <= addr_q + 1'b1;
                    byte_idx_q <= byte_idx_q + 1'b1;
                    if (addr_q == '1) wrap_q <= 1'b1;
                    if (byte_idx_q == 2'd3) remaining_q <= remaining_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              checksum <= '0;
        else if (state_q == IDLE && start)       checksum <= '0;
        else if (state_q == ACCEPT && in_valid)  checksum <= checksum ^ in_data;
    end
`endif

endmodule
